// File: rtl/eth_pkg.sv
// Shared Ethernet data-path types: the 34-bit FIFO word layout and the
// transmit FSM state encoding. Used by both the receive and transmit sides.
package eth_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORD_W  = 34;
    localparam int unsigned SOP_BIT = 32;
    localparam int unsigned EOP_BIT = 33;

    // FIFO word as stored by the receive side: {eop, sop, data}
    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } eth_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XMIT  = 2'd1,
        FLUSH = 2'd2,
        GAP   = 2'd3
    } xmt_state_t;

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports: clk, resetN (sync, active-low), inc (count enable), cnt (value).
module eth_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/eth_xmt_fsm.sv
// Transmit-side framer: drains {eop,sop,data} words from a FWFT egress FIFO
// onto the 32-bit port, enforcing an inter-packet gap, dropping stray words,
// aborting oversize or unterminated packets and counting packets/errors.
// Ports:
//   clk, resetN          clock, synchronous active-low reset
//   txEn                 allows new packets to start
//   fifoEmpty, fifoData  FIFO status and head word
//   fifoRdEn             pop strobe (combinational)
//   outValid/outData/outSop/outEop/outAbort  registered port interface
//   pktCnt, errCnt       saturating statistics
module eth_xmt_fsm
    import eth_pkg::*;
#(
    parameter int unsigned IPG       = 2,
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              txEn,
    input  logic              fifoEmpty,
    input  logic [33:0]       fifoData,
    output logic              fifoRdEn,
    output logic              outValid,
    output logic [31:0]       outData,
    output logic              outSop,
    output logic              outEop,
    output logic              outAbort,
    output logic [CNT_W-1:0]  pktCnt,
    output logic [CNT_W-1:0]  errCnt
);

    localparam int unsigned WC_W     = $clog2(MAX_WORDS + 1);
    localparam int unsigned GAP_W    = (IPG > 1) ? $clog2(IPG) : 1;
    localparam int unsigned GAP_LAST = (IPG > 0) ? IPG - 1 : 0;
    // With no gap required, packet end returns straight to IDLE
    localparam xmt_state_t  END_ST   = (IPG == 0) ? IDLE : GAP;

    xmt_state_t        state, state_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [WC_W-1:0]   word_cnt, word_cnt_n;
    logic              valid_n, sop_n, eop_n, abort_n;
    logic [31:0]       data_n;
    logic              pop;
    logic              pkt_inc, err_inc;

    logic              head_sop, head_eop;
    logic [31:0]       head_data;

    assign head_sop  = fifoData[SOP_BIT];
    assign head_eop  = fifoData[EOP_BIT];
    assign head_data = fifoData[DATA_W-1:0];

    // No pop may escape while the block is held in reset
    assign fifoRdEn  = pop & resetN;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            word_cnt <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outSop   <= 1'b0;
            outEop   <= 1'b0;
            outAbort <= 1'b0;
        end else begin
            state    <= state_n;
            gap_cnt  <= gap_cnt_n;
            word_cnt <= word_cnt_n;
            outValid <= valid_n;
            outData  <= data_n;
            outSop   <= sop_n;
            outEop   <= eop_n;
            outAbort <= abort_n;
        end
    end

    // Next-state, pop and next-output decode
    always_comb begin
        state_n    = state;
        gap_cnt_n  = gap_cnt;
        word_cnt_n = word_cnt;
        valid_n    = 1'b0;
        sop_n      = 1'b0;
        eop_n      = 1'b0;
        abort_n    = 1'b0;
        data_n     = outData;
        pop        = 1'b0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    if (!head_sop) begin
                        // Stray word outside a packet: drop even when disabled
                        pop     = 1'b1;
                        err_inc = 1'b1;
                    end else if (txEn) begin
                        pop        = 1'b1;
                        valid_n    = 1'b1;
                        sop_n      = 1'b1;
                        data_n     = head_data;
                        word_cnt_n = WC_W'(1);
                        if (head_eop) begin
                            eop_n     = 1'b1;
                            pkt_inc   = 1'b1;
                            gap_cnt_n = '0;
                            state_n   = END_ST;
                        end else begin
                            state_n   = XMIT;
                        end
                    end
                end
            end

            XMIT: begin
                if (!fifoEmpty) begin
                    if (head_sop) begin
                        // Next packet began without our eop: void this one,
                        // leave its sop word for IDLE to pick up
                        abort_n   = 1'b1;
                        err_inc   = 1'b1;
                        gap_cnt_n = '0;
                        state_n   = END_ST;
                    end else if (head_eop) begin
                        pop       = 1'b1;
                        valid_n   = 1'b1;
                        eop_n     = 1'b1;
                        data_n    = head_data;
                        pkt_inc   = 1'b1;
                        gap_cnt_n = '0;
                        state_n   = END_ST;
                    end else if (word_cnt == WC_W'(MAX_WORDS)) begin
                        abort_n   = 1'b1;
                        err_inc   = 1'b1;
                        state_n   = FLUSH;
                    end else begin
                        pop        = 1'b1;
                        valid_n    = 1'b1;
                        data_n     = head_data;
                        word_cnt_n = word_cnt + WC_W'(1);
                    end
                end
            end

            FLUSH: begin
                // Silently drain the rest of an oversize packet
                if (!fifoEmpty) begin
                    if (head_sop) begin
                        gap_cnt_n = '0;
                        state_n   = END_ST;
                    end else begin
                        pop = 1'b1;
                        if (head_eop) begin
                            gap_cnt_n = '0;
                            state_n   = END_ST;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    eth_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
        .clk    (clk),
        .resetN (resetN),
        .inc    (pkt_inc),
        .cnt    (pktCnt)
    );

    eth_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk    (clk),
        .resetN (resetN),
        .inc    (err_inc),
        .cnt    (errCnt)
    );

endmodule

// File: doc/eth_xmt_fsm.md
Name: eth_xmt_fsm

Overview:
- Transmit-side framer for the Ethernet switch data path.
- Drains 34-bit packet words ({eop, sop, data[31:0]}) from a first-word-fall-through (FWFT) egress FIFO filled by the receive side.
- Drives them onto the 32-bit port interface with registered valid/sop/eop strobes.
- Enforces a minimum inter-packet gap, discards misframed words, aborts oversize packets and keeps saturating packet/error counters.

Parameters:
- IPG, 2: idle cycles forced after every eop or abort; 0 permitted.
- MAX_WORDS, 64: maximum words per packet including the sop word; range 2..65535.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetN  in  1  synchronous, active-low reset.
- txEn  in  1  start enable; a low level blocks new packets only.
- fifoEmpty  in  1  egress FIFO empty.
- fifoData  in  34  FIFO head word; bit 33 = eop, bit 32 = sop; valid when fifoEmpty=0.
- fifoRdEn  out  1  pop; combinational; only asserted when fifoEmpty=0.
- outValid  out  1  outData is valid this cycle.
- outData  out  32  packet word.
- outSop  out  1  first word of packet; qualified by outValid.
- outEop  out  1  last word of packet; qualified by outValid.
- outAbort  out  1  one-cycle pulse, outValid=0: current packet is void.
- pktCnt  out  CNT_W  packets completed with eop; saturating.
- errCnt  out  CNT_W  stray words dropped plus aborts; saturating.

Behaviour:
- Reset (resetN=0 at posedge):
  - state=IDLE, gap counter=0, word counter=0.
  - All registered outputs 0; counters 0.
  - fifoRdEn=0 while resetN=0.
  - Reset mid-packet abandons the packet with no abort pulse; the FIFO is not flushed.
- Output timing:
  - Every out* signal is registered.
  - A word popped in cycle N appears on outData in cycle N+1 with outValid=1.
  - outValid=0 in every cycle without a pop, except for FLUSH pops, which never produce outValid.
  - outData holds its last value when outValid=0.
- IDLE:
  - Acts only when !fifoEmpty.
  - Head sop=0: pop and discard, errCnt+1, stay IDLE. This happens regardless of txEn.
  - Head sop=1 with txEn=1: pop and emit with outSop=1, word count=1.
    - Head eop=1 as well: single-word packet, outEop=1, pktCnt+1, go GAP.
    - Otherwise go XMIT.
  - Head sop=1 with txEn=0: no pop, stay IDLE.
- XMIT:
  - fifoEmpty: no pop, outValid=0, stay XMIT. Mid-packet bubbles are legal.
  - Head sop=1 (missing eop): no pop, outAbort=1 next cycle, errCnt+1, go GAP. The sop word stays at the FIFO head.
  - Head eop=1: pop, emit with outEop=1, pktCnt+1, go GAP.
  - Otherwise, if word count==MAX_WORDS: no pop, outAbort=1, errCnt+1, go FLUSH.
  - Otherwise: pop, emit, word count+1.
  - The sop check has priority over the eop check, and the eop check has priority over the length check.
- FLUSH:
  - Pops and discards words while !fifoEmpty until a word with eop=1 is popped, inclusive, then go GAP.
  - Head sop=1 in FLUSH: no pop, go GAP.
  - No outputs and no counter updates in FLUSH.
- GAP:
  - No pops for exactly IPG cycles, then IDLE.
  - IPG=0: GAP is skipped and the transition goes directly to IDLE.
  - The first pop of the next packet is no earlier than IPG+1 cycles after the eop pop.
- Counters saturate at 2^CNT_W-1 and never wrap.
- txEn dropping mid-packet has no effect until the packet ends.

Decomposition:
- Package eth_pkg holds:
  - typedef eth_word_t (34-bit packed: eop, sop, data).
  - constants SOP_BIT=32, EOP_BIT=33.
  - enum xmt_state_t {IDLE, XMIT, FLUSH, GAP}.
- The receive FSM shares the same package.
- Sub-module eth_sat_cnt (parameter W; inputs clk, resetN, inc; output cnt) is instantiated twice, for pktCnt and errCnt.

Test Plan:
- IPG=2, txEn=1: FIFO holds the 4-word packet {sop,A1},{A2},{A3},{eop,A4}.
  -> outValid high for 4 consecutive cycles; outSop only on A1, outEop only on A4; pktCnt=1; no pop for 2 cycles after the eop pop.
- Single word {sop,eop,0xDEADBEEF}, followed immediately by a second identical word.
  -> two one-cycle packets, each with outSop=outEop=1, separated by exactly 2 idle cycles; pktCnt=2.
- Stray word 0x11111111 without sop in IDLE, followed by a valid 2-word packet.
  -> stray word popped and never emitted; errCnt=1; the packet is emitted normally.
- Packet {sop,B1},{B2}, then {sop,C1},{eop,C2} with no eop on B.
  -> B1 and B2 emitted; outAbort pulses; errCnt=1; after 2 gap cycles C is emitted intact; pktCnt=1.
- MAX_WORDS=4 with a 6-word packet D1..D6 (eop on D6).
  -> D1..D4 emitted, outAbort pulses, D5 and D6 popped silently, then GAP; errCnt=1, pktCnt=0.
- resetN=0 for 1 cycle after the second word of a 5-word packet, with txEn=0 afterwards.
  -> all outputs 0 and counters 0; remaining words without sop are dropped in IDLE; errCnt=3.
